// File: rtl/uart_pkg.sv
// Shared definitions for the beacon/echo UART front end.
// Holds the controller state encoding and the byte width.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT,
    ECHO
  } state_t;

endpackage

// File: rtl/uart_beacon_echo_if.sv
// Byte streams between the controller and the UART rx/tx pair.
// master = controller side, slave = UART side.
interface uart_beacon_echo_if;
  import uart_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_data_valid;
  logic              tx_data_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_data_valid;

  modport master (
    output tx_data,
    output tx_data_valid,
    input  tx_data_ready,
    input  rx_data,
    input  rx_data_valid
  );

  modport slave (
    input  tx_data,
    input  tx_data_valid,
    output tx_data_ready,
    output rx_data,
    output rx_data_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Pointers carry one extra bit so full and empty differ.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_beacon_echo.sv
// Periodic beacon burst sender with an echo path for received bytes.
// Beacon bursts win over echo; rx bytes are buffered in a FIFO.
module uart_beacon_echo
  import uart_pkg::*;
#(
  parameter int MSG_LEN    = 13,
  parameter int PERIOD_CYC = 50000000,
  parameter int FIFO_DEPTH = 16,
  parameter int ECHO_EN    = 1
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [MSG_LEN*BYTE_W-1:0] msg_data,
  uart_beacon_echo_if.master        bus,
  output logic                      busy,
  output logic                      overflow,
  output logic [15:0]               drop_cnt
);

  localparam logic [31:0] LAST_CNT = 32'(PERIOD_CYC - 1);
  localparam logic [7:0]  LAST_IDX = 8'(MSG_LEN - 1);
  localparam int          CW       = $clog2(FIFO_DEPTH) + 1;

  state_t            state, state_n;
  logic [7:0]        idx, idx_n;
  logic [31:0]       cnt, cnt_n;
  logic [BYTE_W-1:0] tx, tx_n;
  logic              vld, vld_n;
  logic              ovf_n;
  logic [15:0]       drop_n;

  logic              xfer;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [BYTE_W-1:0] fdata;
  logic [CW-1:0]     fcount;
  logic              unused_count;

  function automatic logic [BYTE_W-1:0] msg_byte(
    input logic [MSG_LEN*BYTE_W-1:0] msg,
    input logic [7:0]                k
  );
    msg_byte = '0;
    for (int i = 0; i < MSG_LEN; i++)
      if (k == 8'(i)) msg_byte = msg[i*BYTE_W +: BYTE_W];
  endfunction

  assign xfer = vld && bus.tx_data_ready;
  assign push = (ECHO_EN != 0) && bus.rx_data_valid;
  assign unused_count = ^fcount;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.rx_data),
    .rdata (fdata),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    tx_n    = tx;
    vld_n   = vld;
    pop     = 1'b0;
    ovf_n   = overflow;
    drop_n  = drop_cnt;
    unique case (state)
      IDLE: state_n = WAIT;
      SEND: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            idx_n   = '0;
            cnt_n   = '0;
            vld_n   = 1'b0;
            state_n = WAIT;
          end else begin
            idx_n = idx + 8'd1;
            tx_n  = msg_byte(msg_data, idx_n);
          end
        end
      end
      WAIT: begin
        if (cnt != LAST_CNT) cnt_n = cnt + 32'd1;
        if (cnt == LAST_CNT && enable) begin
          idx_n   = '0;
          tx_n    = msg_byte(msg_data, 8'd0);
          vld_n   = 1'b1;
          state_n = SEND;
        end else if (!empty) begin
          pop     = 1'b1;
          tx_n    = fdata;
          vld_n   = 1'b1;
          state_n = ECHO;
        end
      end
      ECHO: begin
        if (cnt != LAST_CNT) cnt_n = cnt + 32'd1;
        if (xfer) begin
          vld_n   = 1'b0;
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
    if (push && full && !pop) begin
      ovf_n = 1'b1;
      if (drop_cnt != 16'hFFFF) drop_n = drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      tx       <= '0;
      vld      <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      tx       <= tx_n;
      vld      <= vld_n;
      overflow <= ovf_n;
      drop_cnt <= drop_n;
    end
  end

  assign bus.tx_data       = tx;
  assign bus.tx_data_valid = vld;
  assign busy              = (state == SEND);

endmodule

// File: tb/tb_uart_beacon_echo.sv
// Directed + randomized bench for uart_beacon_echo.
// Expected streams come from the message text and a FIFO queue model.
module tb_uart_beacon_echo;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] msg_data;
  logic        busy, busy0;
  logic        overflow, ovf0;
  logic [15:0] drop_cnt, drop0;

  uart_beacon_echo_if bus ();
  uart_beacon_echo_if bus0 ();

  assign bus0.tx_data_ready = 1'b1;
  assign bus0.rx_data       = bus.rx_data;
  assign bus0.rx_data_valid = bus.rx_data_valid;

  uart_beacon_echo #(
    .MSG_LEN(4), .PERIOD_CYC(100), .FIFO_DEPTH(4), .ECHO_EN(1)
  ) dut (
    .sys_clk  (clk),
    .rst      (rst),
    .enable   (enable),
    .msg_data (msg_data),
    .bus      (bus),
    .busy     (busy),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  uart_beacon_echo #(
    .MSG_LEN(4), .PERIOD_CYC(100), .FIFO_DEPTH(4), .ECHO_EN(0)
  ) d0 (
    .sys_clk  (clk),
    .rst      (rst),
    .enable   (enable),
    .msg_data (msg_data),
    .bus      (bus0),
    .busy     (busy0),
    .overflow (ovf0),
    .drop_cnt (drop0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_err = 0;
  int d0_n = 0;
  int bad0 = 0;
  logic       stalled = 1'b0;
  logic [7:0] hold = 8'h00;
  logic [7:0] got[$];
  int         got_t[$];
  logic       got_b[$];
  logic [7:0] exp_v[$];
  logic       exp_b[$];
  logic [7:0] fq[$];
  string      txt = "ABCD";

  // transfers complete on the posedge following this negedge sample
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.tx_data_valid && bus.tx_data_ready) begin
        got.push_back(bus.tx_data);
        got_t.push_back(cyc);
        got_b.push_back(busy);
      end
      if (stalled && !(bus.tx_data_valid && bus.tx_data === hold))
        stall_err++;
      stalled = bus.tx_data_valid && !bus.tx_data_ready;
      hold    = bus.tx_data;
      if (bus0.tx_data_valid) begin
        d0_n++;
        if (bus0.tx_data < 8'h41 || bus0.tx_data > 8'h44) bad0++;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_got();
    got.delete();
    got_t.delete();
    got_b.delete();
    exp_v.delete();
    exp_b.delete();
  endtask

  task automatic add_burst();
    for (int i = 0; i < 4; i++) begin
      exp_v.push_back(txt[i]);
      exp_b.push_back(1'b1);
    end
  endtask

  task automatic add_echo(input logic [7:0] b);
    exp_v.push_back(b);
    exp_b.push_back(1'b0);
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({tag, "_timeout"}, 32'(got.size() >= n), 1);
    #1;
  endtask

  task automatic wait_busy(input int budget, input string tag);
    int k = 0;
    while (!busy && k < budget) begin
      step();
      k++;
    end
    check({tag, "_busy"}, 32'(busy), 1);
  endtask

  task automatic check_seq(input string tag);
    int n;
    check({tag, "_len"}, got.size(), exp_v.size());
    n = (got.size() < exp_v.size()) ? got.size() : exp_v.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i), got[i], exp_v[i]);
      check($sformatf("%s_busy%0d", tag, i), got_b[i], exp_b[i]);
    end
  endtask

  initial begin
    int gap;
    int n0;
    logic [7:0] b;
    rst = 1'b1;
    enable = 1'b0;
    msg_data = "DCBA";
    bus.tx_data_ready = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_data_valid = 1'b0;
    repeat (3) step();
    check("rst_valid", bus.tx_data_valid, 0);
    check("rst_data", bus.tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);

    // two back-to-back bursts and the period between them
    rst = 1'b0;
    enable = 1'b1;
    clear_got();
    wait_got(8, 500, "burst");
    add_burst();
    add_burst();
    check_seq("burst");
    gap = (got_t.size() >= 5) ? got_t[4] - got_t[3] : 0;
    check("period_gap", 32'(gap >= 98 && gap <= 102), 1);

    // echo bytes pushed during a burst follow it
    clear_got();
    wait_busy(300, "echo");
    bus.rx_data_valid = 1'b1;
    bus.rx_data = 8'h55;
    step();
    bus.rx_data = 8'h66;
    step();
    bus.rx_data_valid = 1'b0;
    wait_got(10, 400, "echo");
    add_burst();
    add_echo(8'h55);
    add_echo(8'h66);
    add_burst();
    check_seq("echo");

    // six random pushes into a depth-4 FIFO while the burst stalls
    clear_got();
    fq.delete();
    wait_busy(300, "ovf");
    bus.tx_data_ready = 1'b0;
    n0 = 0;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      bus.rx_data_valid = 1'b1;
      bus.rx_data = b;
      if (fq.size() < 4) fq.push_back(b);
      else n0++;
      step();
    end
    bus.rx_data_valid = 1'b0;
    step();
    bus.tx_data_ready = 1'b1;
    wait_got(12, 500, "ovf");
    add_burst();
    foreach (fq[i]) add_echo(fq[i]);
    add_burst();
    check_seq("ovf");
    check("ovf_flag", overflow, 1);
    check("ovf_drop", drop_cnt, n0);
    check("noecho_ovf", ovf0, 0);
    check("noecho_drop", drop0, 0);

    // random backpressure on a whole burst
    clear_got();
    begin
      int k = 0;
      while (got.size() < 4 && k < 2000) begin
        bus.tx_data_ready = 1'($urandom_range(0, 1));
        step();
        k++;
      end
    end
    bus.tx_data_ready = 1'b1;
    step();
    add_burst();
    check_seq("bp");
    check("bp_stable", stall_err, 0);

    // reset right after the second beacon byte
    clear_got();
    wait_got(2, 400, "rstmid");
    rst = 1'b1;
    step();
    check("rstmid_valid", bus.tx_data_valid, 0);
    check("rstmid_drop", drop_cnt, 0);
    check("rstmid_ovf", overflow, 0);
    rst = 1'b0;
    clear_got();
    wait_got(1, 400, "restart");
    enable = 1'b0;
    wait_got(4, 100, "restart");
    add_burst();
    check_seq("restart");

    // beacons off: only the echo byte appears
    clear_got();
    n0 = d0_n;
    step();
    bus.rx_data_valid = 1'b1;
    bus.rx_data = 8'h7A;
    step();
    bus.rx_data_valid = 1'b0;
    repeat (500) step();
    add_echo(8'h7A);
    check_seq("idle_echo");
    check("noecho_out", d0_n - n0, 0);
    check("noecho_beacon", bad0, 0);
    check("final_stable", stall_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_beacon_echo.md
UART_BEACON_ECHO -- requirements
Module: uart_beacon_echo

Interface
REQ-001 SHALL have parameter MSG_LEN, default 13, meaning number of beacon bytes per burst (1..255).
REQ-002 SHALL have parameter PERIOD_CYC, default 50000000, meaning sys_clk cycles from the end of one burst to the start of the next.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning echo FIFO entries (power of two, at least 2).
REQ-004 SHALL have parameter ECHO_EN, default 1, meaning 1 = echo received bytes and 0 = discard them.
REQ-005 SHALL have port sys_clk  in  1  single clock; everything is synchronous to its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port enable  in  1  high = periodic beacon bursts run; low = only echo traffic.
REQ-008 SHALL have port msg_data  in  MSG_LEN*8  beacon text; byte 0 is bits [7:0] and is sent first.
REQ-009 SHALL have port rx_data  in  8  received byte from the UART receiver.
REQ-010 SHALL have port rx_data_valid  in  1  single-cycle strobe marking rx_data valid.
REQ-011 SHALL have port tx_data  out  8  byte offered to the UART transmitter.
REQ-012 SHALL have port tx_data_valid  out  1  tx_data is valid.
REQ-013 SHALL have port tx_data_ready  in  1  transmitter accepts the byte.
REQ-014 SHALL have port busy  out  1  high while in the SEND state.
REQ-015 SHALL have port overflow  out  1  sticky flag: a received byte was dropped.
REQ-016 SHALL have port drop_cnt  out  16  number of dropped bytes, saturating at 16'hFFFF.

Function
REQ-017 SHALL complete a byte transfer only in a cycle where tx_data_valid and tx_data_ready are both high.
REQ-018 SHALL hold tx_data stable while tx_data_valid is high and no transfer has occurred; tx_data_valid SHALL NOT drop before its transfer.
REQ-019 SHALL implement a state machine with states IDLE, SEND, WAIT and ECHO; IDLE->WAIT one cycle after reset is released.
REQ-020 In SEND, the block SHALL present msg_data byte idx (idx counts 0..MSG_LEN-1) and advance idx on each transfer.
REQ-021 On the transfer of byte MSG_LEN-1, the block SHALL clear idx and the period counter, deassert tx_data_valid and go to WAIT.
REQ-022 In WAIT, the period counter SHALL increment every cycle and saturate at PERIOD_CYC-1.
REQ-023 In WAIT, if the counter equals PERIOD_CYC-1 and enable is high, the block SHALL go to SEND; this has priority over echo.
REQ-024 Otherwise in WAIT, if the FIFO is non-empty, the block SHALL pop one byte, go to ECHO and assert tx_data_valid with that byte the next cycle.
REQ-025 In ECHO, on transfer the block SHALL return to WAIT; the period counter SHALL keep counting during ECHO.
REQ-026 The first beacon byte SHALL be presented no later than 2 cycles after entering SEND.
REQ-027 With ECHO_EN=1, every rx_data_valid cycle SHALL write rx_data to the FIFO in any state, including SEND, so no byte is lost while a burst is running.
REQ-028 On a write to a full FIFO (push with no pop in the same cycle), the byte SHALL be discarded, overflow SHALL set and drop_cnt SHALL increment.
REQ-029 A simultaneous push and pop on a full FIFO SHALL succeed with no drop.
REQ-030 With ECHO_EN=0, received bytes SHALL be ignored and the FIFO SHALL stay empty.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra bit to distinguish full from empty.
REQ-032 If enable falls during SEND, the current burst SHALL complete; further bursts SHALL be suppressed while enable is low.
REQ-033 A change on msg_data mid-burst SHALL affect only bytes not yet presented.

Reset
REQ-034 On rst, the block SHALL set state=IDLE, idx=0, period counter=0, tx_data=8'h00, tx_data_valid=0, busy=0, overflow=0, drop_cnt=0 and FIFO empty.
REQ-035 Reset asserted mid-burst or mid-echo SHALL abandon the byte in the same cycle, with no completion transfer.

Structure
REQ-036 A shared package uart_pkg SHALL hold the state encoding enum and the byte width constant (8).
REQ-037 The echo buffer SHALL be a sub-module sync_fifo, parameterised by WIDTH and DEPTH, exposing full, empty and count.
REQ-038 RTL SHALL be within 120-400 lines, with no latches and no combinational path from tx_data_ready to tx_data_valid.

Verification
REQ-039 Test bursts with MSG_LEN=4, msg_data="DCBA" (bytes A,B,C,D), PERIOD_CYC=100, tx_data_ready always 1 -> sequence 41,42,43,44 then a gap of 100 cycles (+/-2), then a repeat.
REQ-040 Test backpressure with tx_data_ready toggled randomly -> each byte is transferred exactly once, in order, with tx_data stable while stalled.
REQ-041 Test echo during a burst: FIFO_DEPTH=4, push 0x55 and 0x66 during SEND -> after 44, output 55,66 before the next burst.
REQ-042 Test overflow: FIFO_DEPTH=4 and 6 pushes during SEND -> 4 bytes echoed, overflow=1, drop_cnt=2.
REQ-043 Test reset mid-burst: assert rst after byte 42 -> next cycle tx_data_valid=0 and drop_cnt=0; after release the burst restarts at 41.
REQ-044 Test enable=0 with ECHO_EN=1: push 0x7A -> only 7A is output and no beacon bytes appear over 500 cycles.
